// File: rtl/localizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : localizer_pkg
// Description : Shared definitions for the acoustic localizer front end:
//               tau width (common with the position solver), microphone
//               count, capture FSM state encoding and the tau saturation
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package localizer_pkg;

  localparam int TAU_W    = 34;
  localparam int NUM_MICS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_OUT     = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  // Clamp a wide signed product into the solver's signed TAU_W-bit range.
  function automatic logic signed [TAU_W-1:0] sat_tau(input logic signed [63:0] v);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (TAU_W - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (TAU_W - 1));
    if (v > hi)
      return hi[TAU_W-1:0];
    else if (v < lo)
      return lo[TAU_W-1:0];
    else
      return v[TAU_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdoa_chan_stamp.sv
`default_nettype none
// ============================================================================
// Module      : tdoa_chan_stamp
// Description : One microphone channel: rising-edge detect on sample ticks,
//               first-edge captured flag and timestamp register.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_sample_en    - sample strobe (edge sampling happens here)
//               i_mic          - comparator level
//               i_arm          - channel may capture a timestamp
//               i_clear        - drop the captured flag
//               i_stamp_val    - timestamp recorded on capture
//               o_hit_now      - this strobe captures (combinational)
//               o_captured     - captured flag
//               o_stamp        - recorded timestamp
// Revision    : 1.0 - initial release
// ============================================================================
module tdoa_chan_stamp #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sample_en,
  input  logic             i_mic,
  input  logic             i_arm,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_stamp_val,
  output logic             o_hit_now,
  output logic             o_captured,
  output logic [CNT_W-1:0] o_stamp
);

  logic             r_prev;
  logic             r_captured;
  logic [CNT_W-1:0] r_stamp;
  logic             w_edge;

  assign w_edge    = i_mic & ~r_prev;
  // Only the first edge of an event counts for this channel.
  assign o_hit_now = i_sample_en & i_arm & w_edge & ~r_captured;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev     <= 1'b0;
      r_captured <= 1'b0;
      r_stamp    <= '0;
    end else begin
      // History tracks the input in every state so a level held high across
      // re-arm is never seen as a fresh edge.
      if (i_sample_en)
        r_prev <= i_mic;
      if (o_hit_now) begin
        r_captured <= 1'b1;
        r_stamp    <= i_stamp_val;
      end else if (i_clear) begin
        r_captured <= 1'b0;
      end
    end
  end

  assign o_captured = r_captured;
  assign o_stamp    = r_stamp;

endmodule
`default_nettype wire

// File: rtl/tdoa_capture.sv
`default_nettype none
// ============================================================================
// Module      : tdoa_capture
// Description : Timestamps the first rising edge of four microphone
//               comparators and outputs (t_i - t_0) * TICK_SCALE, saturated
//               to the solver's signed 34-bit format, with valid/ready and a
//               post-event holdoff.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               sample_en        - sample strobe
//               mic_hit[3:0]     - comparator levels, bit i = mic i
//               tau_ready        - downstream accepts the result
//               tau1..tau3       - signed scaled time differences
//               tau_valid        - result valid
//               err_timeout      - one-cycle pulse on capture window expiry
//               busy             - high in every state except IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module tdoa_capture
  import localizer_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int MAX_LAG       = 1024,
  parameter int TICK_SCALE    = 350,
  parameter int HOLDOFF_TICKS = 4800
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [NUM_MICS-1:0]     mic_hit,
  input  logic                    tau_ready,
  output logic signed [TAU_W-1:0] tau1,
  output logic signed [TAU_W-1:0] tau2,
  output logic signed [TAU_W-1:0] tau3,
  output logic                    tau_valid,
  output logic                    err_timeout,
  output logic                    busy
);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_valid;
  logic                    r_err;
  logic signed [TAU_W-1:0] r_tau     [1:NUM_MICS-1];
  logic signed [TAU_W-1:0] w_tau_sat [1:NUM_MICS-1];

  logic [CNT_W-1:0]    w_cnt_inc;
  logic [CNT_W-1:0]    w_stamp_val;
  logic [CNT_W-1:0]    w_stamp [NUM_MICS];
  logic [NUM_MICS-1:0] w_hit_now;
  logic [NUM_MICS-1:0] w_captured;
  logic [NUM_MICS-1:0] w_flags_next;
  logic                w_arm;
  logic                w_clear;

  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_arm        = (r_state == ST_IDLE) || (r_state == ST_CAPTURE);
  assign w_clear      = ~w_arm;
  // Edges seen in IDLE start the event at tick 0; in CAPTURE the counter is
  // advanced before the edges of the same strobe are stamped.
  assign w_stamp_val  = (r_state == ST_IDLE) ? '0 : w_cnt_inc;
  assign w_flags_next = w_captured | w_hit_now;

  for (genvar i = 0; i < NUM_MICS; i++) begin : g_chan
    tdoa_chan_stamp #(
      .CNT_W (CNT_W)
    ) u_stamp (
      .clk         (clk),
      .rst         (rst),
      .i_sample_en (sample_en),
      .i_mic       (mic_hit[i]),
      .i_arm       (w_arm),
      .i_clear     (w_clear),
      .i_stamp_val (w_stamp_val),
      .o_hit_now   (w_hit_now[i]),
      .o_captured  (w_captured[i]),
      .o_stamp     (w_stamp[i])
    );
  end

  for (genvar i = 1; i < NUM_MICS; i++) begin : g_tau
    logic signed [CNT_W:0] w_diff;
    logic signed [63:0]    w_prod;
    assign w_diff       = $signed({1'b0, w_stamp[i]}) - $signed({1'b0, w_stamp[0]});
    assign w_prod       = 64'(w_diff) * 64'(TICK_SCALE);
    assign w_tau_sat[i] = sat_tau(w_prod);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 1; i < NUM_MICS; i++)
        r_tau[i] <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sample_en && (|w_hit_now)) begin
            r_cnt   <= '0;
            r_state <= (&w_flags_next) ? ST_COMPUTE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (sample_en) begin
            r_cnt <= w_cnt_inc;
            // Completion wins over expiry, so an edge on the last tick counts.
            if (&w_flags_next) begin
              r_state <= ST_COMPUTE;
            end else if (w_cnt_inc == CNT_W'(MAX_LAG)) begin
              r_err   <= 1'b1;
              r_cnt   <= '0;
              r_state <= ST_HOLDOFF;
            end
          end
        end
        ST_COMPUTE: begin
          for (int i = 1; i < NUM_MICS; i++)
            r_tau[i] <= w_tau_sat[i];
          r_valid <= 1'b1;
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          if (tau_ready) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_state <= (HOLDOFF_TICKS == 0) ? ST_IDLE : ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (sample_en) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == CNT_W'(HOLDOFF_TICKS))
              r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tau1        = r_tau[1];
  assign tau2        = r_tau[2];
  assign tau3        = r_tau[3];
  assign tau_valid   = r_valid;
  assign err_timeout = r_err;
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tdoa_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdoa_capture
// Description : Directed self-checking bench for tdoa_capture
//               (TICK_SCALE=350, MAX_LAG=64, HOLDOFF_TICKS=8, strobe every
//               4 clk).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdoa_capture;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_en;
  logic [3:0]         mic_hit;
  logic               tau_ready;
  logic signed [33:0] tau1, tau2, tau3;
  logic               tau_valid, err_timeout, busy;

  int n_checks = 0;
  int n_errors = 0;

  tdoa_capture #(
    .CNT_W         (16),
    .MAX_LAG       (64),
    .TICK_SCALE    (350),
    .HOLDOFF_TICKS (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .mic_hit     (mic_hit),
    .tau_ready   (tau_ready),
    .tau1        (tau1),
    .tau2        (tau2),
    .tau3        (tau3),
    .tau_valid   (tau_valid),
    .err_timeout (err_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // One sample strobe with mic levels m; returns 1 time unit after the edge
  // that samples it.
  task automatic strobe(input logic [3:0] m);
    @(posedge clk); #1;
    mic_hit   = m;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
  endtask

  task automatic idle_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [3:0] m);
    strobe(m);
    idle_clk(2);
  endtask

  task automatic accept();
    tau_ready = 1'b1;
    idle_clk(1);
    tau_ready = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 9; k++) tick(4'b0000);
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_en = 1'b0; mic_hit = 4'b0000; tau_ready = 1'b0;
    idle_clk(3);
    rst = 1'b0;
    n_checks++; if (tau1 !== 34'sd0) begin n_errors++; $display("FAIL reset_tau1: got %0d expected 0", tau1); end
    n_checks++; if (tau2 !== 34'sd0) begin n_errors++; $display("FAIL reset_tau2: got %0d expected 0", tau2); end
    n_checks++; if (tau3 !== 34'sd0) begin n_errors++; $display("FAIL reset_tau3: got %0d expected 0", tau3); end
    n_checks++; if ({tau_valid, err_timeout, busy} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b expected 000", {tau_valid, err_timeout, busy}); end
  endtask

  task automatic test_basic();
    tick(4'b0001);
    for (int t = 1; t <= 2; t++) tick(4'b0001);
    for (int t = 3; t <= 4; t++) tick(4'b0011);
    for (int t = 5; t <= 9; t++) tick(4'b0111);
    strobe(4'b1111);
    n_checks++; if (tau_valid !== 1'b0) begin n_errors++; $display("FAIL basic_latency1: valid got %b expected 0", tau_valid); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    idle_clk(1);
    n_checks++; if (tau_valid !== 1'b1) begin n_errors++; $display("FAIL basic_latency2: valid got %b expected 1", tau_valid); end
    n_checks++; if (tau1 !== 34'sd1050) begin n_errors++; $display("FAIL basic_tau1: got %0d expected 1050", tau1); end
    n_checks++; if (tau2 !== 34'sd1750) begin n_errors++; $display("FAIL basic_tau2: got %0d expected 1750", tau2); end
    n_checks++; if (tau3 !== 34'sd3500) begin n_errors++; $display("FAIL basic_tau3: got %0d expected 3500", tau3); end
    accept();
    n_checks++; if (tau_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drop: valid got %b expected 0", tau_valid); end
    drain();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_rearm: busy got %b expected 0", busy); end
  endtask

  task automatic test_reorder();
    for (int t = 0; t <= 3; t++) tick(4'b0100);
    for (int t = 4; t <= 6; t++) tick(4'b0111);
    strobe(4'b1111);
    idle_clk(1);
    n_checks++; if (tau_valid !== 1'b1) begin n_errors++; $display("FAIL reorder_valid: got %b expected 1", tau_valid); end
    n_checks++; if (tau1 !== 34'sd0) begin n_errors++; $display("FAIL reorder_tau1: got %0d expected 0", tau1); end
    n_checks++; if (tau2 !== -34'sd1400) begin n_errors++; $display("FAIL reorder_tau2: got %0d expected -1400", tau2); end
    n_checks++; if (tau3 !== 34'sd1050) begin n_errors++; $display("FAIL reorder_tau3: got %0d expected 1050", tau3); end
    accept();
    drain();
  endtask

  task automatic test_simultaneous();
    tau_ready = 1'b1;
    strobe(4'b1111);
    n_checks++; if (tau_valid !== 1'b0) begin n_errors++; $display("FAIL simul_latency1: valid got %b expected 0", tau_valid); end
    idle_clk(1);
    n_checks++; if (tau_valid !== 1'b1) begin n_errors++; $display("FAIL simul_valid: got %b expected 1", tau_valid); end
    n_checks++; if ({tau1, tau2, tau3} !== 102'd0) begin n_errors++; $display("FAIL simul_taus: got %0d %0d %0d expected 0 0 0", tau1, tau2, tau3); end
    idle_clk(1);
    n_checks++; if (tau_valid !== 1'b0) begin n_errors++; $display("FAIL simul_zero_wait: valid got %b expected 0", tau_valid); end
    tau_ready = 1'b0;
    drain();
  endtask

  task automatic test_timeout();
    int err_seen;
    err_seen = 0;
    tick(4'b0111);
    for (int t = 1; t <= 63; t++) begin
      strobe(4'b0111);
      if (err_timeout) err_seen++;
      idle_clk(2);
    end
    n_checks++; if (err_seen !== 0) begin n_errors++; $display("FAIL timeout_early: pulses got %0d expected 0", err_seen); end
    strobe(4'b0111);
    n_checks++; if (err_timeout !== 1'b1) begin n_errors++; $display("FAIL timeout_pulse: got %b expected 1", err_timeout); end
    idle_clk(1);
    n_checks++; if ({err_timeout, tau_valid} !== 2'b00) begin n_errors++; $display("FAIL timeout_single: err,valid got %b expected 00", {err_timeout, tau_valid}); end
    for (int k = 0; k < 7; k++) begin
      strobe(4'b0111);
      idle_clk(2);
    end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL holdoff_busy: got %b expected 1", busy); end
    strobe(4'b0111);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL holdoff_rearm: busy got %b expected 0", busy); end
    idle_clk(2);
    strobe(4'b0111);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL holdoff_held_high: busy got %b expected 0", busy); end
    idle_clk(2);
  endtask

  task automatic test_lag_boundary();
    tick(4'b0000);
    tick(4'b0111);
    for (int t = 1; t <= 63; t++) tick(4'b0111);
    strobe(4'b1111);
    n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL lag_err: got %b expected 0", err_timeout); end
    idle_clk(1);
    n_checks++; if (tau_valid !== 1'b1) begin n_errors++; $display("FAIL lag_valid: got %b expected 1", tau_valid); end
    n_checks++; if (tau3 !== 34'sd22400) begin n_errors++; $display("FAIL lag_tau3: got %0d expected 22400", tau3); end
    n_checks++; if ({tau1, tau2} !== 68'd0) begin n_errors++; $display("FAIL lag_tau12: got %0d %0d expected 0 0", tau1, tau2); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      mic_hit   = i[3:0] ^ 4'b0101;
      sample_en = (i % 4 == 0);
    end
    sample_en = 1'b0;
    idle_clk(1);
    n_checks++; if ({tau_valid, busy} !== 2'b11) begin n_errors++; $display("FAIL stall_valid: valid,busy got %b expected 11", {tau_valid, busy}); end
    n_checks++; if (tau3 !== 34'sd22400 || tau1 !== 34'sd0 || tau2 !== 34'sd0) begin n_errors++; $display("FAIL stall_taus: got %0d %0d %0d expected 0 0 22400", tau1, tau2, tau3); end
    tick(4'b1111);
    accept();
    n_checks++; if (tau_valid !== 1'b0) begin n_errors++; $display("FAIL stall_transfer: valid got %b expected 0", tau_valid); end
    n_checks++; if (tau3 !== 34'sd22400) begin n_errors++; $display("FAIL stall_hold_tau3: got %0d expected 22400", tau3); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL stall_holdoff: busy got %b expected 1", busy); end
    for (int k = 0; k < 8; k++) tick(4'b1111);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL stall_rearm: busy got %b expected 0", busy); end
    tick(4'b1111);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL stall_held_high: busy got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    tick(4'b0000);
    tick(4'b0001);
    strobe(4'b0011);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rstmid_capturing: busy got %b expected 1", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if ({tau_valid, err_timeout, busy} !== 3'b000) begin n_errors++; $display("FAIL rstmid_flags: got %b expected 000", {tau_valid, err_timeout, busy}); end
    n_checks++; if ({tau1, tau2, tau3} !== 102'd0) begin n_errors++; $display("FAIL rstmid_taus: got %0d %0d %0d expected 0 0 0", tau1, tau2, tau3); end
    tick(4'b0000);
    tick(4'b1000);
    tick(4'b1001);
    tick(4'b1011);
    strobe(4'b1111);
    idle_clk(1);
    n_checks++; if (tau_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_valid: got %b expected 1", tau_valid); end
    n_checks++; if (tau1 !== 34'sd350) begin n_errors++; $display("FAIL rstmid_tau1: got %0d expected 350", tau1); end
    n_checks++; if (tau2 !== 34'sd700) begin n_errors++; $display("FAIL rstmid_tau2: got %0d expected 700", tau2); end
    n_checks++; if (tau3 !== -34'sd350) begin n_errors++; $display("FAIL rstmid_tau3: got %0d expected -350", tau3); end
    accept();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reorder();
    test_simultaneous();
    test_timeout();
    test_lag_boundary();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
